// File: rtl/mdu_iter_if.sv
// Request/response bundle between the core pipeline and the iterative MUL/DIV unit.
// The master side issues operands; the slave side returns the write-back result.
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;
    logic            we;

    modport master (
        output start, funct3, a, b, rd_in,
        input  busy, done, result, rd_out, we
    );

    modport slave (
        input  start, funct3, a, b, rd_in,
        output busy, done, result, rd_out, we
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with the divide-by-zero and signed-overflow cases resolved at issue.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    mdu_iter_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_n;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              sa_q, sb_q;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   hi, lo, mag_b, result_q;

    // Issue-time decode
    logic              a_signed, b_signed, sa, sb, div0, ovf, special, accept, last;
    logic [XLEN-1:0]   mag_a_in, mag_b_in, spec_res;

    assign a_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                      (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign b_signed = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b110);
    assign sa       = a_signed & bus.a[XLEN-1];
    assign sb       = b_signed & bus.b[XLEN-1];
    assign mag_a_in = sa ? -bus.a : bus.a;
    assign mag_b_in = sb ? -bus.b : bus.b;
    assign div0     = bus.funct3[2] && (bus.b == '0);
    assign ovf      = bus.funct3[2] && !bus.funct3[0] && (bus.a == MIN_NEG) && (bus.b == '1);
    assign special  = div0 || ovf;
    assign spec_res = div0 ? (bus.funct3[1] ? bus.a : '1)
                           : (bus.funct3[1] ? '0 : MIN_NEG);
    assign accept   = (state == S_IDLE) && bus.start;
    assign last     = (cnt == CNT_W'(XLEN - 1));

    // Multiply step: conditionally add multiplicand into the high half, then shift right.
    logic [XLEN:0]     msum;
    logic [XLEN-1:0]   mul_hi_n, mul_lo_n;
    assign msum     = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : {(XLEN+1){1'b0}});
    assign mul_hi_n = msum[XLEN:1];
    assign mul_lo_n = {msum[0], lo[XLEN-1:1]};

    // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in.
    logic [XLEN:0]     dshift, dtrial;
    logic              dge;
    logic [XLEN-1:0]   div_hi_n, div_lo_n;
    assign dshift   = {hi, lo[XLEN-1]};
    assign dtrial   = dshift - {1'b0, mag_b};
    assign dge      = !dtrial[XLEN];
    assign div_hi_n = dge ? dtrial[XLEN-1:0] : dshift[XLEN-1:0];
    assign div_lo_n = {lo[XLEN-2:0], dge};

    // Sign fix-up applied to the values produced by the final iteration.
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   quo_f, rem_f, final_res;
    assign prod     = {mul_hi_n, mul_lo_n};
    assign prod_f   = (sa_q ^ sb_q) ? -prod : prod;
    assign quo_f    = (sa_q ^ sb_q) ? -div_lo_n : div_lo_n;
    assign rem_f    = sa_q ? -div_hi_n : div_hi_n;
    assign final_res = op_q[2] ? (op_q[1] ? rem_f : quo_f)
                               : ((op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        bus.we     = 1'b0;
        bus.result = result_q;
        bus.rd_out = rd_q;
        unique case (state)
            S_IDLE: if (bus.start) state_n = special ? S_DONE : S_CALC;
            S_CALC: begin
                bus.busy = 1'b1;
                if (last) state_n = S_DONE;
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                bus.we   = (rd_q != 5'd0);
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mag_b    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= bus.funct3;
            rd_q  <= bus.rd_in;
            sa_q  <= sa;
            sb_q  <= sb;
            cnt   <= '0;
            hi    <= '0;
            lo    <= mag_a_in;
            mag_b <= mag_b_in;
            if (special) result_q <= spec_res;
        end else if (state == S_CALC) begin
            cnt <= cnt + 1'b1;
            hi  <= op_q[2] ? div_hi_n : mul_hi_n;
            lo  <= op_q[2] ? div_lo_n : mul_lo_n;
            if (last) result_q <= final_res;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed-vector bench for mdu_iter: hand-computed results, latency, busy width,
// write-enable gating, ignored starts and reset abort.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mdu_iter_if #(.XLEN(32)) bus ();

    mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, scramble operands after acceptance, optionally re-pulse start while
    // busy, and re-pulse start in the done cycle (must be ignored).
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                          input logic [31:0] bv, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat, input int repulse);
        int k;
        int nbusy;
        int ndone;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.a      = av;
        bus.b      = bv;
        bus.rd_in  = rd;
        cyc();
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = bv ^ 32'h5a5a_a5a5;
        bus.rd_in = 5'd31;
        k = 1;
        nbusy = 0;
        while (!bus.done && k < 60) begin
            if (bus.busy) nbusy++;
            if (k == repulse) begin
                bus.start  = 1'b1;
                bus.funct3 = 3'b000;
                bus.a      = 32'd100;
                bus.b      = 32'd100;
                bus.rd_in  = 5'd9;
            end
            cyc();
            bus.start = 1'b0;
            k++;
        end
        if (bus.busy) nbusy++;
        check_eq({tag, " latency"}, 32'(k), 32'(exp_lat));
        check_eq({tag, " result"}, bus.result, exp);
        check_eq({tag, " rd_out"}, {27'd0, bus.rd_out}, {27'd0, rd});
        check_eq({tag, " we"}, {31'd0, bus.we}, {31'd0, (rd != 5'd0)});
        check_eq({tag, " busy cycles"}, 32'(nbusy), 32'(exp_lat));
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.a      = 32'd1;
        bus.b      = 32'd1;
        cyc();
        bus.start = 1'b0;
        check_eq({tag, " done pulse"}, {31'd0, bus.done}, 32'd0);
        check_eq({tag, " idle after done"}, {31'd0, bus.busy}, 32'd0);
        check_eq({tag, " result held"}, bus.result, exp);
        if (repulse != 0) begin
            ndone = 0;
            for (int i = 0; i < 40; i++) begin
                if (bus.done) ndone++;
                cyc();
            end
            check_eq({tag, " no second done"}, 32'(ndone), 32'd0);
        end
    endtask

    initial begin
        int ndone;
        bus.start  = 1'b0;
        bus.funct3 = 3'b000;
        bus.a      = '0;
        bus.b      = '0;
        bus.rd_in  = '0;
        // Reset asserted together with start: reset wins.
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.a      = 32'd7;
        bus.b      = 32'd6;
        bus.rd_in  = 5'd5;
        cyc();
        cyc();
        rst       = 1'b0;
        bus.start = 1'b0;
        check_eq("reset busy", {31'd0, bus.busy}, 32'd0);
        check_eq("reset done", {31'd0, bus.done}, 32'd0);
        check_eq("reset we", {31'd0, bus.we}, 32'd0);
        check_eq("reset result", bus.result, 32'd0);
        check_eq("reset rd_out", {27'd0, bus.rd_out}, 32'd0);
        cyc();
        check_eq("rst+start ignored", {31'd0, bus.busy}, 32'd0);

        run_op("MUL 7x6",      3'b000, 32'd7,         32'd6,         5'd5,  32'd42,        33, 0);
        run_op("MUL -3x5",     3'b000, 32'hFFFF_FFFD, 32'd5,         5'd1,  32'hFFFF_FFF1, 33, 0);
        run_op("MULH",         3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33, 0);
        run_op("MULHSU",       3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33, 0);
        run_op("MULHU",        3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 33, 0);
        run_op("DIV -7/2",     3'b100, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33, 0);
        run_op("REM -7%2",     3'b110, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33, 0);
        run_op("DIVU",         3'b101, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'h7FFF_FFFC, 33, 0);
        run_op("REMU",         3'b111, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'h0000_0001, 33, 0);
        run_op("DIVU by 0",    3'b101, 32'd123,       32'd0,         5'd10, 32'hFFFF_FFFF, 1,  0);
        run_op("DIV by 0",     3'b100, 32'd5,         32'd0,         5'd11, 32'hFFFF_FFFF, 1,  0);
        run_op("REM by 0",     3'b110, 32'd5,         32'd0,         5'd12, 32'd5,         1,  0);
        run_op("REM ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1,  0);
        run_op("DIV ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1,  0);
        run_op("MUL repulse",  3'b000, 32'd7,         32'd6,         5'd5,  32'd42,        33, 10);
        run_op("MUL rd0",      3'b000, 32'd3,         32'd4,         5'd0,  32'd12,        33, 0);

        // Reset in the middle of a divide aborts it.
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.a      = 32'd100;
        bus.b      = 32'd7;
        bus.rd_in  = 5'd3;
        cyc();
        bus.start = 1'b0;
        for (int k = 1; k < 15; k++) cyc();
        check_eq("mid-op busy before rst", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_eq("abort busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort done", {31'd0, bus.done}, 32'd0);
        check_eq("abort we", {31'd0, bus.we}, 32'd0);
        check_eq("abort result", bus.result, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done || bus.we) ndone++;
            cyc();
        end
        check_eq("abort no done", 32'(ndone), 32'd0);
        run_op("MUL 3x4 after abort", 3'b000, 32'd3, 32'd4, 5'd7, 32'd12, 33, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit that sits between the register file read ports and the register write port.
- Consumes rs1/rs2 operand values, computes over multiple cycles, and returns the result plus destination index for write-back.
- Core control holds the PC and suppresses the normal ALU write while `busy` is high.
- Radix-2 shift-add multiply and restoring divide; one bit per cycle.

Parameters:
- XLEN, 32, operand/result width; fixed at 32 for RV32, parameterised for bench reuse
- CNT_W, 6, iteration counter width; must hold the value XLEN

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  request pulse; sampled only in IDLE
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  XLEN  operand from register file read port 1 (rs1 value)
- b  input  XLEN  operand from register file read port 2 (rs2 value)
- rd_in  input  5  destination register index
- busy  output  1  high from the cycle after start is accepted until the cycle DONE is left
- done  output  1  one-cycle pulse; result valid
- result  output  XLEN  computed value; held until the next accepted start
- rd_out  output  5  latched rd_in
- we  output  1  register write enable; equals done AND (rd_out != 0)

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE
  - busy, done, we = 0
  - result = 0, rd_out = 0
  - counter and internal registers = 0
- Reset mid-operation aborts the operation: no done and no we is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - If start=1, latch funct3, rd_in, and operand magnitudes plus sign flags.
  - Signedness of a: signed for MULH, MULHSU, DIV, REM.
  - Signedness of b: signed for MULH, DIV, REM.
  - Next state is CALC with counter = 0, except for the special cases below, which go directly to DONE.
- CALC:
  - Performs one iteration per cycle.
  - After XLEN iterations (counter reaches XLEN-1), apply the sign fix-up and go to DONE.
- Sign fix-up:
  - Product is negated if the operand signs differ (signed-as-applicable).
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of a.
- Result selection:
  - MUL returns product[31:0].
  - MULH, MULHSU, MULHU return product[63:32].
- DONE: done=1 and result valid for exactly one cycle; next state is IDLE.
- Latency:
  - Normal ops: start accepted at cycle N → done at cycle N+XLEN+1 (N+33), with busy high for XLEN+1 cycles.
  - Special cases: done at N+1, with busy high for 1 cycle.
- Special cases (resolved in IDLE, no iteration):
  - Divide by zero: DIV/DIVU quotient = all ones (0xFFFFFFFF); REM/REMU = a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- start while busy=1 or in DONE is ignored; no queueing.
- Operands a/b may change after acceptance without effect.
- start asserted in the same cycle as done: ignored, because the state is DONE. The request must be reissued in IDLE.
- rst and start in the same cycle: rst wins.
- result and rd_out hold their values after done until the next accepted start.

Test Plan:
- MUL: a=7, b=6, rd_in=5, start pulse → done exactly 33 cycles after acceptance, result=42, rd_out=5, we=1 for one cycle, busy high for 33 cycles.
- MULH / MULHSU / MULHU: a=0xFFFFFFFF, b=0xFFFFFFFF → results 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV / REM / DIVU: a=-7 (0xFFFFFFF9), b=2 → DIV=0xFFFFFFFD (-3), REM=0xFFFFFFFF (-1), DIVU=0x7FFFFFFC.
- Special cases: DIVU a=123, b=0 → result=0xFFFFFFFF, done 1 cycle after accept. REM with a=0x80000000, b=0xFFFFFFFF → result=0, done 1 cycle after accept.
- Ignored starts and rd=0:
  - start re-pulsed at cycle 10 of a running MUL with different operands → first result unchanged, no second done.
  - rd_in=0 → done=1, we=0.
- Reset mid-operation: assert rst at cycle 15 of a DIV → next cycle busy=0, state IDLE, no done/we. A fresh MUL 3×4 afterwards returns 12.
